// File: rtl/dmem_agen_pkg.sv
// Shared types and helpers for the strided data-memory address generator.
// Default geometry widths plus the divider-free modular block step.
package dmem_agen_pkg;

  localparam int unsigned NUM_BLK_DEF   = 7;
  localparam int unsigned BLK_DEPTH_DEF = 16;
  localparam int unsigned BLK_W         = $clog2(NUM_BLK_DEF);
  localparam int unsigned OFF_W         = $clog2(BLK_DEPTH_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // (blk + step) mod num_blk, valid for blk, step < num_blk
  function automatic int unsigned blk_step(input int unsigned blk,
                                           input int unsigned step,
                                           input int unsigned num_blk);
    int unsigned sum;
    sum = blk + step;
    return (sum >= num_blk) ? (sum - num_blk) : sum;
  endfunction

endpackage

// File: rtl/dmem_stride_agen_mod_blk_step.sv
// Combinational modular block advance used for both the stride step and the
// per-group start-block step.
module mod_blk_step
  import dmem_agen_pkg::*;
#(
  parameter int unsigned NUM_BLK  = NUM_BLK_DEF,
  parameter int unsigned BLK_BITS = $clog2(NUM_BLK)
) (
  input  logic [BLK_BITS-1:0] blk,
  input  logic [BLK_BITS-1:0] step,
  output logic [BLK_BITS-1:0] sum_c
);

  assign sum_c = BLK_BITS'(blk_step(32'(blk), 32'(step), NUM_BLK));

endmodule

// File: rtl/dmem_stride_agen.sv
// Data-memory address generator: strided block walk per group, idle gap
// between groups, valid/ready stalls, finite or free-running group count.
module dmem_stride_agen
  import dmem_agen_pkg::*;
#(
  parameter int unsigned NUM_BLK      = NUM_BLK_DEF,
  parameter int unsigned BLK_DEPTH    = BLK_DEPTH_DEF,
  parameter int unsigned STRIDE       = 3,
  parameter int unsigned BLKS_PER_GRP = 3,
  parameter int unsigned GAP          = 2,
  parameter int unsigned GRP_CNT_W    = 8,
  localparam int unsigned BLK_BITS    = $clog2(NUM_BLK),
  localparam int unsigned OFF_BITS    = $clog2(BLK_DEPTH),
  localparam int unsigned ADDR_W      = BLK_BITS + OFF_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cfg_linear,
  input  logic [GRP_CNT_W-1:0] cfg_num_grp,
  output logic [ADDR_W-1:0]    addr,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic                 grp_first,
  output logic                 grp_last,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned SUB_W    = (BLKS_PER_GRP > 1) ? $clog2(BLKS_PER_GRP) : 1;
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam int unsigned SUB_LAST = BLKS_PER_GRP - 1;
  localparam int unsigned OFF_LAST = BLK_DEPTH - 1;

  state_e               state_q, state_d;
  logic [BLK_BITS-1:0]  blk_q, blk_d, start_blk_q, start_blk_d;
  logic [OFF_BITS-1:0]  off_q, off_d;
  logic [SUB_W-1:0]     sub_q, sub_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [GRP_CNT_W-1:0] grp_q, grp_d, num_grp_q, num_grp_d;
  logic                 linear_q, linear_d;
  logic                 valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic [BLK_BITS-1:0]  step_sel;
  logic [BLK_BITS-1:0]  blk_stride_c;
  logic [BLK_BITS-1:0]  start_inc_c;

  assign step_sel = linear_q ? BLK_BITS'(1) : BLK_BITS'(STRIDE);

  mod_blk_step #(.NUM_BLK(NUM_BLK), .BLK_BITS(BLK_BITS)) u_stride_step (
    .blk   (blk_q),
    .step  (step_sel),
    .sum_c (blk_stride_c)
  );

  mod_blk_step #(.NUM_BLK(NUM_BLK), .BLK_BITS(BLK_BITS)) u_grp_step (
    .blk   (start_blk_q),
    .step  (BLK_BITS'(1)),
    .sum_c (start_inc_c)
  );

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      blk_q       <= '0;
      start_blk_q <= '0;
      off_q       <= '0;
      sub_q       <= '0;
      gap_q       <= '0;
      grp_q       <= '0;
      num_grp_q   <= '0;
      linear_q    <= 1'b0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      start_blk_q <= start_blk_d;
      off_q       <= off_d;
      sub_q       <= sub_d;
      gap_q       <= gap_d;
      grp_q       <= grp_d;
      num_grp_q   <= num_grp_d;
      linear_q    <= linear_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    start_blk_d = start_blk_q;
    off_d       = off_q;
    sub_d       = sub_q;
    gap_d       = gap_q;
    grp_d       = grp_q;
    num_grp_d   = num_grp_q;
    linear_d    = linear_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          linear_d    = cfg_linear;
          num_grp_d   = cfg_num_grp;
          start_blk_d = '0;
          blk_d       = '0;
          off_d       = '0;
          sub_d       = '0;
          grp_d       = '0;
        end
      end
      S_RUN: begin
        if (addr_ready) begin
          if (off_q != OFF_BITS'(OFF_LAST)) begin
            off_d = off_q + 1'b1;
          end else if (sub_q != SUB_W'(SUB_LAST)) begin
            off_d = '0;
            sub_d = sub_q + 1'b1;
            blk_d = blk_stride_c;
          end else if ((num_grp_q != '0) &&
                       (GRP_CNT_W'(grp_q + 1'b1) == num_grp_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            // addr holds the last beat's address through the gap
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            start_blk_d = start_inc_c;
            blk_d       = start_inc_c;
            off_d       = '0;
            sub_d       = '0;
            grp_d       = grp_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d     = S_RUN;
          start_blk_d = start_inc_c;
          blk_d       = start_inc_c;
          off_d       = '0;
          sub_d       = '0;
          grp_d       = grp_q + 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end

    valid_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    first_d = valid_d && (sub_d == '0) && (off_d == '0);
    last_d  = valid_d && (sub_d == SUB_W'(SUB_LAST)) && (off_d == OFF_BITS'(OFF_LAST));
  end

  assign addr       = {blk_q, off_q};
  assign addr_valid = valid_q;
  assign grp_first  = first_q;
  assign grp_last   = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dmem_stride_agen.sv
// Randomized bench for dmem_stride_agen: a default-GAP and a GAP=0 instance
// share stimulus and are both scored against an arithmetic beat-sequence model.
module tb_dmem_stride_agen;

  localparam int unsigned AW    = dmem_agen_pkg::BLK_W + dmem_agen_pkg::OFF_W;
  localparam int          NB    = 7;
  localparam int          DEPTH = 16;
  localparam int          STR   = 3;
  localparam int          BPG   = 3;

  typedef struct {
    int addr;
    bit first;
    bit last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          cfg_linear;
  logic [7:0]    cfg_num_grp;
  logic          addr_ready;
  logic [AW-1:0] addr_o  [2];
  logic          valid_o [2];
  logic          first_o [2];
  logic          last_o  [2];
  logic          busy_o  [2];
  logic          done_o  [2];

  int    n_chk;
  int    n_pass;
  beat_t exp_q[$];

  dmem_stride_agen #(.GAP(2)) u_dut_gap2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_linear(cfg_linear), .cfg_num_grp(cfg_num_grp),
    .addr(addr_o[0]), .addr_valid(valid_o[0]), .addr_ready(addr_ready),
    .grp_first(first_o[0]), .grp_last(last_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  dmem_stride_agen #(.GAP(0)) u_dut_gap0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_linear(cfg_linear), .cfg_num_grp(cfg_num_grp),
    .addr(addr_o[1]), .addr_valid(valid_o[1]), .addr_ready(addr_ready),
    .grp_first(first_o[1]), .grp_last(last_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Expected accepted-beat stream: group g starts at block g mod NB and walks BPG blocks
  task automatic build_model(input bit lin, input int groups);
    int s;
    beat_t b;
    exp_q.delete();
    s = lin ? 1 : STR;
    for (int g = 0; g < groups; g++)
      for (int k = 0; k < BPG; k++)
        for (int o = 0; o < DEPTH; o++) begin
          b.addr  = (((g % NB) + k * s) % NB) * DEPTH + o;
          b.first = (k == 0) && (o == 0);
          b.last  = (k == BPG - 1) && (o == DEPTH - 1);
          exp_q.push_back(b);
        end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++)
      check(tag, {29'd0, valid_o[d], busy_o[d], done_o[d]}, 32'd0);
  endtask

  task automatic run(input bit lin, input int ng, input int model_grp, input int rdy_pct,
                     input bit stall5, input int abort_at, input bit restart_mid);
    int         ptr  [2];
    bit         fin  [2];
    bit         ing  [2];
    int         gcnt [2];
    logic       pv   [2];
    logic [31:0] pa  [2];
    logic       pf   [2];
    logic       pl   [2];
    logic       pr;
    int         len;
    int         stall_left;
    bit         armed;
    bit         aborting;
    bit         ended;

    build_model(lin, model_grp);
    len = exp_q.size();
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; fin[d] = 0; ing[d] = 0; gcnt[d] = 0; pv[d] = 0;
      pa[d] = 0; pf[d] = 0; pl[d] = 0;
    end
    pr = 1'b0; stall_left = 0; armed = 1; aborting = 0; ended = 0;

    cfg_linear  = lin;
    cfg_num_grp = 8'(ng);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 6000 && !ended; cyc++) begin
      if (aborting) begin
        abort = 1'b0;
        check_idle("abort_idle");
        ended = 1;
      end else begin
        // A second start with different config while busy must be ignored
        start = restart_mid && (cyc == 20);
        if (start) begin
          cfg_num_grp = 8'd1;
          cfg_linear  = ~lin;
        end

        if (stall5 && armed && stall_left == 0 && valid_o[0] && last_o[0]) begin
          stall_left = 5;
          armed      = 0;
        end
        addr_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
        if (stall_left > 0) stall_left--;

        for (int d = 0; d < 2; d++) begin
          if (!fin[d] && !(ng == 0 && ptr[d] >= len)) begin
            if (done_o[d]) begin
              check("done_at_end", 32'((ng != 0) && (ptr[d] == len)), 32'd1);
              check("busy_at_done", 32'(busy_o[d]), 32'd0);
              fin[d] = 1;
            end else if (ng != 0 && ptr[d] == len) begin
              check("done_pulse", 32'd0, 32'd1);
              fin[d] = 1;
            end else begin
              if (pv[d] && !pr)
                check("stall_hold", {valid_o[d], first_o[d], last_o[d], 29'(addr_o[d])},
                      {1'b1, pf[d], pl[d], 29'(pa[d])});
              if (valid_o[d]) begin
                if (ing[d]) begin
                  check("gap_len", 32'(gcnt[d]), 32'(gap_of(d)));
                  ing[d] = 0;
                end
                if (addr_ready) begin
                  check("beat_addr", 32'(addr_o[d]), 32'(exp_q[ptr[d]].addr));
                  check("beat_flags", {30'd0, first_o[d], last_o[d]},
                        {30'd0, exp_q[ptr[d]].first, exp_q[ptr[d]].last});
                  if (exp_q[ptr[d]].last) begin
                    if (d == 0) armed = 1;
                    if (ptr[d] + 1 < len) begin
                      ing[d]  = 1;
                      gcnt[d] = 0;
                    end
                  end
                  ptr[d]++;
                end
              end else if (ing[d]) begin
                gcnt[d]++;
              end else begin
                check("valid_drop", 32'(valid_o[d]), 32'd1);
              end
              pv[d] = valid_o[d];
              pa[d] = 32'(addr_o[d]);
              pf[d] = first_o[d];
              pl[d] = last_o[d];
            end
          end
        end
        pr = addr_ready;

        if (abort_at > 0 && ptr[0] >= abort_at) begin
          abort    = 1'b1;
          aborting = 1;
        end
        if (fin[0] && fin[1]) ended = 1;
        if (!ended) begin
          @(posedge clk); #1;
        end
      end
    end
    if (!ended) check("timeout", 32'd0, 32'd1);
    start      = 1'b0;
    abort      = 1'b0;
    addr_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst         = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    cfg_linear  = 1'b0;
    cfg_num_grp = 8'd0;
    addr_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      check("reset_outputs", {valid_o[d], first_o[d], last_o[d], busy_o[d], done_o[d], 27'(addr_o[d])},
            32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // start and abort together: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort");

    run(1'b0, 3, 3, 100, 1'b0, 0, 1'b0);
    run(1'b0, 0, 9, 100, 1'b0, 8 * 48 + 20, 1'b0);
    run(1'b0, 3, 3, 70, 1'b1, 0, 1'b1);
    run(1'b1, 2, 2, 60, 1'b0, 0, 1'b0);
    run(1'b0, 4, 4, 50, 1'b1, 0, 1'b0);

    // reset in the middle of a run
    cfg_linear  = 1'b0;
    cfg_num_grp = 8'd3;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      check("mid_reset", {valid_o[d], first_o[d], last_o[d], busy_o[d], done_o[d], 27'(addr_o[d])},
            32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
